// File: rtl/wb_stage.sv
// Write-back stage: picks the register-file write data (link address, ALU result or
// extracted load data) and keeps a one-cycle registered copy for forwarding.
module wb_stage #(
    parameter int BUS_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_mem_to_reg,
    input  logic [BUS_WIDTH-1:0]      i_alu_result,
    input  logic [BUS_WIDTH-1:0]      i_mem_result,
    input  logic [1:0]                i_mem_width,
    input  logic                      i_mem_unsigned,
    input  logic [1:0]                i_byte_offset,
    input  logic                      i_link,
    input  logic [BUS_WIDTH-1:0]      i_pc_plus8,
    input  logic                      i_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    output logic [BUS_WIDTH-1:0]      o_wb_data,
    output logic                      o_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic [BUS_WIDTH-1:0]      o_fwd_data,
    output logic [REG_ADDR_WIDTH-1:0] o_fwd_rd,
    output logic                      o_fwd_valid
);

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;

    logic [7:0]                byte_lane;
    logic [15:0]               half_lane;
    logic [BUS_WIDTH-1:0]      load_data;

    logic [BUS_WIDTH-1:0]      fwd_data_d, fwd_data_q;
    logic [REG_ADDR_WIDTH-1:0] fwd_rd_d,   fwd_rd_q;
    logic                      fwd_valid_d, fwd_valid_q;

    // Little-endian lane selection; half loads ignore offset bit 0.
    always_comb begin
        byte_lane = 8'h00;
        case (i_byte_offset)
            2'd0:    byte_lane = i_mem_result[7:0];
            2'd1:    byte_lane = i_mem_result[15:8];
            2'd2:    byte_lane = i_mem_result[23:16];
            default: byte_lane = i_mem_result[31:24];
        endcase
        half_lane = i_byte_offset[1] ? i_mem_result[31:16] : i_mem_result[15:0];
    end

    always_comb begin
        load_data = i_mem_result;
        case (i_mem_width)
            WIDTH_BYTE: begin
                if (i_mem_unsigned)
                    load_data = {{(BUS_WIDTH-8){1'b0}}, byte_lane};
                else
                    load_data = {{(BUS_WIDTH-8){byte_lane[7]}}, byte_lane};
            end
            WIDTH_HALF: begin
                if (i_mem_unsigned)
                    load_data = {{(BUS_WIDTH-16){1'b0}}, half_lane};
                else
                    load_data = {{(BUS_WIDTH-16){half_lane[15]}}, half_lane};
            end
            default: load_data = i_mem_result;
        endcase
    end

    // Link wins over everything; mem_to_reg=1 deliberately means "take the ALU result".
    always_comb begin
        o_wb_data = load_data;
        if (i_link)
            o_wb_data = i_pc_plus8;
        else if (i_mem_to_reg)
            o_wb_data = i_alu_result;
        o_reg_write = i_reg_write && (i_rd != '0);
        o_rd        = i_rd;
    end

    always_comb begin
        fwd_data_d  = o_wb_data;
        fwd_rd_d    = o_rd;
        fwd_valid_d = o_reg_write;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fwd_data_q  <= '0;
            fwd_rd_q    <= '0;
            fwd_valid_q <= 1'b0;
        end else begin
            fwd_data_q  <= fwd_data_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_valid_q <= fwd_valid_d;
        end
    end

    assign o_fwd_data  = fwd_data_q;
    assign o_fwd_rd    = fwd_rd_q;
    assign o_fwd_valid = fwd_valid_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, reset sequences and randomized
// traffic compared against an arithmetic reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_result = '0;
    logic [1:0]  mem_width = '0;
    logic        mem_unsigned = 1'b0;
    logic [1:0]  byte_offset = '0;
    logic        link = 1'b0;
    logic [31:0] pc_plus8 = '0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] fwd_data;
    logic [4:0]  fwd_rd;
    logic        fwd_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        link;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [1:0]  width;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] pc8;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs[$];

    wb_stage #(.BUS_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .i_clk(clk), .i_reset(rst), .i_mem_to_reg(mem_to_reg),
        .i_alu_result(alu_result), .i_mem_result(mem_result),
        .i_mem_width(mem_width), .i_mem_unsigned(mem_unsigned),
        .i_byte_offset(byte_offset), .i_link(link), .i_pc_plus8(pc_plus8),
        .i_reg_write(reg_write), .i_rd(rd),
        .o_wb_data(wb_data), .o_reg_write(wb_we), .o_rd(wb_rd),
        .o_fwd_data(fwd_data), .o_fwd_rd(fwd_rd), .o_fwd_valid(fwd_valid)
    );

    always #5 clk = ~clk;

    // Reference: load value from shifts and masks, sign extension by subtracting 2^n.
    function automatic logic [31:0] ref_wb(input logic lk, input logic m2r,
                                           input logic [31:0] alu, input logic [31:0] mem,
                                           input logic [1:0] width, input logic uns,
                                           input logic [1:0] off, input logic [31:0] pc8);
        logic [31:0] v;
        if (lk) return pc8;
        if (m2r) return alu;
        if (width == 2'd0) begin
            v = (mem >> (32'(off) * 8)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (width == 2'd1) begin
            v = (mem >> ((32'(off) / 2) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic lk, input logic m2r, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [1:0] width, input logic uns,
                           input logic [1:0] off, input logic [31:0] pc8, input logic we,
                           input logic [4:0] r, input logic [31:0] ed, input logic ew);
        vec_t v;
        v.link = lk; v.m2r = m2r; v.alu = alu; v.mem = mem; v.width = width;
        v.uns = uns; v.off = off; v.pc8 = pc8; v.we = we; v.rd = r;
        v.exp_data = ed; v.exp_we = ew;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic lk, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [1:0] width, input logic uns,
                         input logic [1:0] off, input logic [31:0] pc8, input logic we,
                         input logic [4:0] r);
        link = lk; mem_to_reg = m2r; alu_result = alu; mem_result = mem;
        mem_width = width; mem_unsigned = uns; byte_offset = off;
        pc_plus8 = pc8; reg_write = we; rd = r;
    endtask

    task automatic check_fwd(input string tag, input logic [31:0] d, input logic [4:0] r,
                             input logic v);
        check_val({tag, "_data"},  fwd_data, d);
        check_val({tag, "_rd"},    32'(fwd_rd), 32'(r));
        check_val({tag, "_valid"}, 32'(fwd_valid), 32'(v));
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_w;
        logic [4:0]  exp_r;

        // link m2r alu mem width uns off pc8 we rd | exp_data exp_we
        add_vec(0, 1, 32'h12345678, 32'h87654321, 2'd2, 0, 2'd0, 32'h0, 1, 5'd3, 32'h12345678, 1);
        add_vec(0, 0, 32'h12345678, 32'h87654321, 2'd2, 0, 2'd0, 32'h0, 1, 5'd3, 32'h87654321, 1);
        add_vec(0, 1, 32'h00000000, 32'hFFFFFFFF, 2'd2, 0, 2'd0, 32'h0, 1, 5'd3, 32'h00000000, 1);
        add_vec(0, 0, 32'h0, 32'h80F07F01, 2'd0, 0, 2'd0, 32'h0, 1, 5'd4, 32'h00000001, 1);
        add_vec(0, 0, 32'h0, 32'h80F07F01, 2'd0, 0, 2'd1, 32'h0, 1, 5'd4, 32'h0000007F, 1);
        add_vec(0, 0, 32'h0, 32'h80F07F01, 2'd0, 0, 2'd2, 32'h0, 1, 5'd4, 32'hFFFFFFF0, 1);
        add_vec(0, 0, 32'h0, 32'h80F07F01, 2'd0, 0, 2'd3, 32'h0, 1, 5'd4, 32'hFFFFFF80, 1);
        add_vec(0, 0, 32'h0, 32'h80F07F01, 2'd0, 1, 2'd3, 32'h0, 1, 5'd4, 32'h00000080, 1);
        add_vec(0, 0, 32'h0, 32'h8001F00F, 2'd1, 0, 2'd0, 32'h0, 1, 5'd6, 32'hFFFFF00F, 1);
        add_vec(0, 0, 32'h0, 32'h8001F00F, 2'd1, 1, 2'd2, 32'h0, 1, 5'd6, 32'h00008001, 1);
        add_vec(0, 0, 32'h0, 32'h8001F00F, 2'd1, 0, 2'd3, 32'h0, 1, 5'd6, 32'hFFFF8001, 1);
        add_vec(0, 0, 32'h0, 32'h8001F00F, 2'd3, 1, 2'd3, 32'h0, 1, 5'd6, 32'h8001F00F, 1);
        add_vec(1, 0, 32'h1, 32'h2, 2'd0, 0, 2'd0, 32'h00400010, 1, 5'd0, 32'h00400010, 0);
        add_vec(1, 1, 32'h1, 32'h2, 2'd0, 0, 2'd0, 32'h00400010, 1, 5'd31, 32'h00400010, 1);
        add_vec(0, 1, 32'hDEADBEEF, 32'h2, 2'd0, 0, 2'd0, 32'h0, 0, 5'd9, 32'hDEADBEEF, 0);

        // Asynchronous reset clears the registered copy without a clock edge.
        #2 rst = 1'b1;
        #1 check_fwd("reset_state", 32'h0, 5'd0, 1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].link, vecs[i].m2r, vecs[i].alu, vecs[i].mem, vecs[i].width,
                  vecs[i].uns, vecs[i].off, vecs[i].pc8, vecs[i].we, vecs[i].rd);
            #1;
            check_val($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
            check_val($sformatf("vec%0d_we", i), 32'(wb_we), 32'(vecs[i].exp_we));
            check_val($sformatf("vec%0d_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
        end

        // Reset held across an edge keeps the registered copy at zero.
        @(negedge clk);
        drive(0, 1, 32'h55AA55AA, 32'h0, 2'd2, 0, 2'd0, 32'h0, 1, 5'd7);
        @(posedge clk);
        #1 check_fwd("reset_held", 32'h0, 5'd0, 1'b0);
        check_val("comb_during_reset", wb_data, 32'h55AA55AA);

        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 32'hCAFEF00D, 32'h0, 2'd2, 0, 2'd0, 32'h0, 1, 5'd5);
        @(posedge clk);
        #1 check_fwd("capture", 32'hCAFEF00D, 5'd5, 1'b1);
        #2 rst = 1'b1;
        #1 check_fwd("async_clear", 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom, $urandom,
                  2'($urandom), 1'($urandom), 2'($urandom), $urandom,
                  1'($urandom), 5'($urandom_range(0, 31)));
            exp_d = ref_wb(link, mem_to_reg, alu_result, mem_result, mem_width,
                           mem_unsigned, byte_offset, pc_plus8);
            exp_w = reg_write && (rd != 5'd0);
            exp_r = rd;
            #1;
            check_val("rand_data", wb_data, exp_d);
            check_val("rand_we", 32'(wb_we), 32'(exp_w));
            check_val("rand_rd", 32'(wb_rd), 32'(exp_r));
            @(posedge clk);
            #1 check_fwd("rand_fwd", exp_d, exp_r, exp_w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS32 pipeline.
- Selects the register-file write data from the ALU result, the load data or the link address.
- Applies load-width extraction and sign/zero extension to the memory word.
- Drives the register-file write port combinationally, and registers a one-cycle copy of the write for the hazard/forwarding unit.

Parameters:
- BUS_WIDTH, 32, data path width in bits; the load-extraction logic requires 32.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- i_clk  input  1  single system clock; the registered copy updates on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_mem_to_reg  input  1  source select: 1 selects the ALU result, 0 selects the memory result.
- i_alu_result  input  BUS_WIDTH  ALU result from MEM/WB.
- i_mem_result  input  BUS_WIDTH  raw aligned word read from data memory.
- i_mem_width  input  2  load width: 00 byte, 01 half, 10 or 11 word.
- i_mem_unsigned  input  1  1 zero-extends a byte/half load, 0 sign-extends it.
- i_byte_offset  input  2  address bits [1:0] of the load.
- i_link  input  1  JAL/JALR/BGEZAL-type write of the link address.
- i_pc_plus8  input  BUS_WIDTH  link address.
- i_reg_write  input  1  register write request.
- i_rd  input  REG_ADDR_WIDTH  destination register.
- o_wb_data  output  BUS_WIDTH  write data to the register file (combinational).
- o_reg_write  output  1  gated write enable (combinational).
- o_rd  output  REG_ADDR_WIDTH  destination register passthrough (combinational).
- o_fwd_data  output  BUS_WIDTH  registered o_wb_data.
- o_fwd_rd  output  REG_ADDR_WIDTH  registered o_rd.
- o_fwd_valid  output  1  registered o_reg_write.

Behaviour:
- Combinational path, zero latency; not affected by the clock or reset.
- Source priority: i_link=1 gives o_wb_data = i_pc_plus8 regardless of i_mem_to_reg.
- Otherwise i_mem_to_reg=1 gives o_wb_data = i_alu_result.
- Otherwise i_mem_to_reg=0 gives o_wb_data = load_data. This inverted polarity is intentional and mandatory.
- Load extraction uses little-endian lanes.
- Byte load: lane = i_mem_result[8*off+7 : 8*off], with off = i_byte_offset.
- Half load: lane = i_mem_result[16*off[1]+15 : 16*off[1]]; i_byte_offset[0] is ignored (alignment is checked upstream).
- Word load: load_data = i_mem_result unmodified, with offset, unsigned and width ignored.
- Byte/half extension: zero-extend if i_mem_unsigned=1, else replicate the lane MSB.
- Write gating: o_reg_write = i_reg_write AND (i_rd != 0).
- o_rd = i_rd always.
- o_wb_data is driven even when o_reg_write=0.
- Registered copy: on each rising edge of i_clk, o_fwd_data ← o_wb_data, o_fwd_rd ← o_rd, o_fwd_valid ← o_reg_write.
- Reset: i_reset=1 asynchronously clears o_fwd_data, o_fwd_rd and o_fwd_valid to 0 immediately, independent of the clock.
- Reset held: the registered outputs hold 0 while i_reset is high.
- Reset release: capture resumes on the first rising edge after deassertion.
- Reset mid-operation: the combinational outputs keep tracking their inputs during reset.
- All inputs are assumed known; X inputs propagate and no X-masking is performed.

Test Plan:
- i_link=0, i_mem_to_reg=1, alu=32'h12345678, mem=32'h87654321 -> o_wb_data=32'h12345678 after settle, no clock needed. Then i_mem_to_reg=0, width=word -> 32'h87654321. Then i_mem_to_reg=1, alu=32'h00000000, mem=32'hFFFFFFFF -> 32'h00000000.
- i_mem_to_reg=0, mem=32'h80F07F01, byte load with offsets 0..3, signed -> 32'h00000001, 32'h0000007F, 32'hFFFFFFF0, 32'hFFFFFF80. Unsigned offset 3 -> 32'h00000080.
- Half load, mem=32'h8001F00F. Offset 0 signed -> 32'hFFFFF00F. Offset 2 unsigned -> 32'h00008001. Offset 3 signed -> 32'hFFFF8001.
- i_link=1, pc_plus8=32'h00400010, i_mem_to_reg=0 -> o_wb_data=32'h00400010. i_reg_write=1, i_rd=0 -> o_reg_write=0. i_rd=31 -> o_reg_write=1, o_rd=31.
- Registered copy: reset high -> fwd outputs 0. Release, drive alu=32'hCAFEF00D, i_mem_to_reg=1, rd=5, write=1, then clock -> o_fwd_data=32'hCAFEF00D, o_fwd_rd=5, o_fwd_valid=1. Assert i_reset between edges -> all fwd outputs 0 immediately.
